// File: rtl/c2c_pkg.sv
// Shared definitions for the chip-to-chip burst receiver: control state
// encoding and the width helper used to size its counters.
package c2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACK   = 2'd2,
    ST_DATA  = 2'd3
  } state_e;

  // Bits needed for a counter that runs from 0 to n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/c2c_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: rdata always shows the head entry.
// A push while full and a pop while empty are both dropped.
module c2c_sync_fifo
  import c2c_pkg::*;
#(
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = cnt_w(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;
  logic              do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // NOTE: storage has no reset; emptiness is tracked by count, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == LW'(FIFO_DEPTH));
  assign level = count;

endmodule

// File: rtl/c2c_slave_burst_rx.sv
// Slave side of a request/ack burst link: waits ACK_DELAY cycles before
// acknowledging, then buffers BURST_LEN words (or times out) into a FWFT FIFO.
module c2c_slave_burst_rx
  import c2c_pkg::*;
#(
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned ACK_DELAY  = 100000000,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          request,
  input  logic                          valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          rd_en,
  output logic                          ack,
  output logic                          notice,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          timeout_err
);

  localparam int unsigned DLY_W = cnt_w(ACK_DELAY);
  localparam int unsigned WRD_W = cnt_w(BURST_LEN);
  localparam int unsigned IDL_W = cnt_w(TIMEOUT);

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [WRD_W-1:0]   word_q, word_d;
  logic [IDL_W-1:0]   idle_q, idle_d;
  logic               terr_q, terr_d;
  logic               push;
  logic               free_ok;

  // A burst is only granted when the whole burst is guaranteed to fit.
  assign free_ok = (32'(FIFO_DEPTH) - 32'(level)) >= 32'(BURST_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      word_q  <= '0;
      idle_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      word_q  <= word_d;
      idle_q  <= idle_d;
      terr_q  <= terr_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    word_d  = word_q;
    idle_d  = idle_q;
    terr_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dly_d = '0;
        if (request && free_ok) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (!request) begin
          state_d = ST_IDLE;
          dly_d   = '0;
        end else if (dly_q == DLY_W'(ACK_DELAY - 1)) begin
          state_d = ST_ACK;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_DATA;
        word_d  = '0;
        idle_d  = '0;
      end
      ST_DATA: begin
        if (valid) begin
          push   = 1'b1;
          idle_d = '0;
          if (word_q == WRD_W'(BURST_LEN - 1)) begin
            state_d = ST_IDLE;
            word_d  = '0;
          end else begin
            word_d = word_q + WRD_W'(1);
          end
        end else if (idle_q == IDL_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          idle_d  = '0;
          word_d  = '0;
          terr_d  = 1'b1;
        end else begin
          idle_d = idle_q + IDL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack         = (state_q == ST_ACK) || (state_q == ST_DATA);
  assign notice      = (state_q == ST_DELAY);
  assign timeout_err = terr_q;

  c2c_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (data_in),
    .pop   (rd_en),
    .rdata (rd_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_c2c_slave_burst_rx.sv
// Bench for c2c_slave_burst_rx: timing checks from a cycle model of the handshake,
// plus a queue scoreboard whose monitor checks every word popped from the FIFO.
module tb_c2c_slave_burst_rx;

  localparam int unsigned DATA_W     = 3;
  localparam int unsigned ACK_DELAY  = 4;
  localparam int unsigned BURST_LEN  = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 8;
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              request;
  logic              valid;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              ack;
  logic              notice;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [LW-1:0]     level;
  logic              timeout_err;

  int n_pass   = 0;
  int n_checks = 0;
  logic [DATA_W-1:0] exp_q[$];
  int mlevel = 0;

  c2c_slave_burst_rx #(
    .DATA_W     (DATA_W),
    .ACK_DELAY  (ACK_DELAY),
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .valid       (valid),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .ack         (ack),
    .notice      (notice),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted pop must present the oldest word the bench pushed.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got %0d expected no data at %0t", rd_data, $time);
      end else begin
        check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_word();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (mlevel > 0) mlevel--;
    check("pop_level", 32'(level), 32'(mlevel));
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit last);
    valid   = 1'b1;
    data_in = d;
    exp_q.push_back(d);
    tick();
    valid = 1'b0;
    mlevel++;
    check("word_ack", 32'(ack), last ? 32'd0 : 32'd1);
    check("word_level", 32'(level), 32'(mlevel));
  endtask

  // Called right after the edge that entered DELAY; leaves the bench in the first DATA cycle.
  task automatic handshake();
    for (int i = 1; i < int'(ACK_DELAY); i++) begin
      tick();
      check("delay_notice", 32'(notice), 32'd1);
      check("delay_ack", 32'(ack), 32'd0);
    end
    tick();
    check("ack_rise", 32'(ack), 32'd1);
    check("ack_notice_low", 32'(notice), 32'd0);
    request = 1'b0;
    valid   = 1'b1;
    data_in = DATA_W'($urandom_range(0, 7));
    tick();
    valid = 1'b0;
    check("data_ack", 32'(ack), 32'd1);
    check("ack_valid_ignored", 32'(level), 32'(mlevel));
  endtask

  task automatic start_request();
    request = 1'b1;
    tick();
    check("notice_rise", 32'(notice), 32'd1);
    check("notice_ack_low", 32'(ack), 32'd0);
  endtask

  task automatic drain();
    while (mlevel > 0) pop_word();
    check("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    bit seen;
    int gap;
    int npop;
    rst_n   = 1'b0;
    request = 1'b0;
    valid   = 1'b0;
    data_in = '0;
    rd_en   = 1'b0;
    tick();
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_notice", 32'(notice), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    tick();

    // Pop on an empty FIFO is ignored.
    pop_word();
    check("empty_pop_empty", 32'(empty), 32'd1);

    // Directed burst of 5 then 2.
    start_request();
    handshake();
    send_word(3'd5, 1'b0);
    send_word(3'd2, 1'b1);
    check("burst_notice", 32'(notice), 32'd0);
    drain();

    // Abort: request drops during the second DELAY cycle.
    start_request();
    tick();
    request = 1'b0;
    tick();
    check("abort_notice", 32'(notice), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < int'(ACK_DELAY) + 3; i++) begin
      tick();
      if (ack || notice) seen = 1'b1;
    end
    check("abort_no_ack", 32'(seen), 32'd0);
    check("abort_level", 32'(level), 32'd0);

    // Backpressure: fill, leave one free slot, then free a second slot with request held.
    start_request();
    handshake();
    send_word(DATA_W'($urandom_range(0, 7)), 1'b0);
    send_word(DATA_W'($urandom_range(0, 7)), 1'b1);
    start_request();
    handshake();
    send_word(DATA_W'($urandom_range(0, 7)), 1'b0);
    send_word(DATA_W'($urandom_range(0, 7)), 1'b1);
    check("bp_full", 32'(full), 32'd1);
    pop_word();
    request = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack || notice) seen = 1'b1;
    end
    check("bp_held_off", 32'(seen), 32'd0);
    pop_word();
    check("bp_still_idle", 32'(notice), 32'd0);
    tick();
    check("bp_notice", 32'(notice), 32'd1);
    handshake();
    send_word(DATA_W'($urandom_range(0, 7)), 1'b0);
    send_word(DATA_W'($urandom_range(0, 7)), 1'b1);
    check("bp_full2", 32'(full), 32'd1);
    drain();

    // Timeout after one word.
    start_request();
    handshake();
    send_word(DATA_W'($urandom_range(0, 7)), 1'b0);
    seen = 1'b0;
    for (int i = 1; i < int'(TIMEOUT); i++) begin
      tick();
      if (timeout_err || !ack) seen = 1'b1;
    end
    check("to_not_early", 32'(seen), 32'd0);
    tick();
    check("to_pulse", 32'(timeout_err), 32'd1);
    check("to_ack", 32'(ack), 32'd0);
    tick();
    check("to_pulse_end", 32'(timeout_err), 32'd0);
    check("to_level", 32'(level), 32'd1);

    // Simultaneous push and pop at level 2.
    start_request();
    handshake();
    send_word(DATA_W'($urandom_range(0, 7)), 1'b0);
    valid   = 1'b1;
    data_in = DATA_W'($urandom_range(0, 7));
    exp_q.push_back(data_in);
    rd_en   = 1'b1;
    tick();
    valid = 1'b0;
    rd_en = 1'b0;
    check("pushpop_level", 32'(level), 32'd2);
    check("pushpop_ack", 32'(ack), 32'd0);
    drain();

    // Random bursts with random gaps and partial drains, wrapping the pointers.
    for (int it = 0; it < 8; it++) begin
      while (mlevel > int'(FIFO_DEPTH - BURST_LEN)) pop_word();
      start_request();
      handshake();
      for (int k = 0; k < int'(BURST_LEN); k++) begin
        gap = int'($urandom_range(0, TIMEOUT - 2));
        for (int g = 0; g < gap; g++) tick();
        send_word(DATA_W'($urandom_range(0, 7)), k == int'(BURST_LEN) - 1);
      end
      npop = int'($urandom_range(0, mlevel));
      for (int p = 0; p < npop; p++) pop_word();
    end
    drain();

    // Asynchronous reset mid-DATA with one word buffered.
    start_request();
    handshake();
    send_word(DATA_W'($urandom_range(0, 7)), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(ack), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_level", 32'(level), 32'd0);
    exp_q.delete();
    mlevel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle_notice", 32'(notice), 32'd0);
    check("arst_idle_ack", 32'(ack), 32'd0);
    start_request();
    handshake();
    send_word(DATA_W'($urandom_range(0, 7)), 1'b0);
    send_word(DATA_W'($urandom_range(0, 7)), 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/c2c_slave_burst_rx.md
C2C_SLAVE_BURST_RX -- requirements
Module: c2c_slave_burst_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 3: width of each data word.
REQ-002 SHALL have parameter ACK_DELAY, default 100000000: cycles from request acceptance to ack assertion, legal range ≥1.
REQ-003 SHALL have parameter BURST_LEN, default 4: number of words per transaction, legal range ≥1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: receive buffer entries, power of two, ≥ BURST_LEN.
REQ-005 SHALL have parameter TIMEOUT, default 1000: maximum idle cycles between words in the data phase, legal range ≥1.
REQ-006 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- request  in  1  master transaction request, level, synchronous to clk.
- valid  in  1  data_in qualifier, one word per high cycle.
- data_in  in  DATA_W  incoming word.
- rd_en  in  1  consumer pop request.
- ack  out  1  handshake acknowledge to master.
- notice  out  1  request seen, ack pending.
- rd_data  out  DATA_W  FIFO head word.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds FIFO_DEPTH words.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- timeout_err  out  1  one-cycle pulse on data-phase timeout.

Function
REQ-007 SHALL implement the states IDLE, DELAY, ACK and DATA, all registered.
REQ-008 In IDLE, request=1 with free space (FIFO_DEPTH-level) ≥ BURST_LEN SHALL move to DELAY on that edge; notice=1 from the same edge.
REQ-009 In IDLE, request=1 with insufficient free space SHALL keep the block in IDLE with notice=0 and ack=0; the request is held off until space frees.
REQ-010 DELAY SHALL count clock cycles and SHALL move to ACK with ack=1 and notice=0 at the edge ACK_DELAY cycles after entry.
REQ-011 request falling to 0 in DELAY SHALL abort to IDLE at the next edge, clearing notice and the delay counter, with ack staying 0.
REQ-012 ACK SHALL last exactly one cycle with ack=1, then move to DATA.
REQ-013 DATA SHALL hold ack=1 and SHALL push data_in into the FIFO on each cycle valid=1.
REQ-014 DATA SHALL leave for IDLE at the edge that pushes word BURST_LEN; ack=0 from that edge.
REQ-015 DATA SHALL count consecutive valid=0 cycles; on reaching TIMEOUT it SHALL return to IDLE, drop ack and pulse timeout_err for 1 cycle. Words already pushed stay in the FIFO.
REQ-016 valid outside DATA SHALL be ignored.
REQ-017 The FIFO SHALL be first-word-fall-through: rd_data shows the head whenever empty=0, and rd_en=1 pops it at the edge.
REQ-018 rd_en while empty SHALL be ignored, with no pointer or level change.
REQ-019 A simultaneous push and pop SHALL leave level unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 A push while full cannot occur by construction (REQ-008). If it is forced, it SHALL be dropped.
REQ-021 The word counter and timeout counter SHALL clear on every entry to DATA.

Reset
REQ-022 rst_n=0 SHALL immediately force the following values, regardless of clk:
- state IDLE.
- ack=0, notice=0, timeout_err=0.
- all counters 0.
- FIFO pointers 0, level=0, empty=1, full=0.
REQ-023 Reset asserted mid-transaction SHALL discard buffered words. After release, the block SHALL start in IDLE and requires a fresh request.

Structure
REQ-024 State encoding and a counter-width helper constant SHALL live in shared package c2c_pkg.
REQ-025 The FIFO SHALL be the sub-module c2c_sync_fifo, parametrised by DATA_W and FIFO_DEPTH. Control and counters stay in the top module.

Verification (DATA_W=3, ACK_DELAY=4, BURST_LEN=2, FIFO_DEPTH=4, TIMEOUT=8)
REQ-026 Normal burst:
- Stimulus: request=1 at cycle 0, then valid with data 5 and 2.
- Response: notice=1 cycles 1-4, ack=1 from cycle 5, FIFO gets 5,2, ack=0 after the 2nd word, level=2.
REQ-027 Abort: request deasserted at cycle 2 of DELAY -> notice=0 next cycle, ack never rises, level stays 0.
REQ-028 Backpressure:
- Stimulus: level=3 (free space 1), request=1.
- Response: notice=0 and ack=0 until one rd_en pop brings level to 2, then DELAY starts.
REQ-029 Timeout: in DATA, 1 word then 8 idle cycles -> timeout_err pulses once, ack=0, level=1.
REQ-030 FIFO edges:
- rd_en on empty -> no change.
- Simultaneous push and pop at level=2 -> level stays 2.
- Fill and drain twice -> data order preserved across pointer wrap.
REQ-031 Async reset: rst_n low mid-DATA with level=1 -> ack=0, empty=1 and level=0 with no clock edge.
